// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: host-side issue controller for the fpu core.
// Accepts one request over valid/ready and holds the operands on the fpu
// inputs. It waits the op's fixed latency, then captures the result and
// flags and returns them over a valid/ready response port. Only one
// operation is in flight at a time.
// Optional build macro FPU_STICKY_FLAGS_EN adds the sticky_clr input and an
// OR-accumulated sticky_flags output.
module fpu_issue_ctrl #(
  parameter int LAT_ADD = 4,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 28,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FPU_STICKY_FLAGS_EN
  input  logic        sticky_clr,
  output logic [7:0]  sticky_flags,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_rmode,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   lat_sel;
  logic               accept;
  logic               op_ok;
  logic               capture;
  logic               retire;

  // Handshake and phase qualifiers; requests are only looked at in IDLE.
  assign accept  = req_valid && (state_q == IDLE);
  assign op_ok   = !req_op[2];
  assign capture = (state_q == WAIT) && (cnt_q == '0);
  assign retire  = (state_q == RESP) && rsp_ready;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  // Fixed latency of the requested op (add/sub share one latency).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    lat_sel = CNT_W'(LAT_DIV);
    case (req_op[1:0])
      2'd0, 2'd1: lat_sel = CNT_W'(LAT_ADD);
      2'd2:       lat_sel = CNT_W'(LAT_MUL);
      default:    lat_sel = CNT_W'(LAT_DIV);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a retiring response always passes through IDLE (no bypass).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_ok ? WAIT : RESP;
      WAIT:    if (capture) state_d = RESP;
      RESP:    if (retire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down to zero while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && op_ok) begin
      cnt_q <= lat_sel;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Operand registers feeding the fpu; they change only on a supported accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_op    <= '0;
      fpu_rmode <= '0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
    end else if (accept && op_ok) begin
      fpu_op    <= req_op;
      fpu_rmode <= req_rmode;
      fpu_opa   <= req_opa;
      fpu_opb   <= req_opb;
    end
  end

  // Response registers: a quiet NaN for unsupported ops, else the fpu capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (accept && !op_ok) begin
      rsp_data  <= QNAN;
      rsp_flags <= '0;
      rsp_err   <= 1'b1;
    end else if (capture) begin
      rsp_data  <= fpu_out;
      rsp_flags <= fpu_flags;
      rsp_err   <= 1'b0;
    end
  end

`ifdef FPU_STICKY_FLAGS_EN
  // Sticky flag accumulator; a clear wins over a capture in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end else if (capture) begin
      sticky_flags <= sticky_flags | fpu_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl. The bench plays the fpu. It drives
// random noise on fpu_out/fpu_flags except on the single cycle the result is
// due, so data is only correct when capture happens at the right edge.
// Expectations come from a latency table and a model of the last issued op.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_rmode;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
`ifdef FPU_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [7:0]  sticky_flags;
  logic [7:0]  sticky_m;
`endif

  fpu_issue_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef FPU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rmode(req_rmode), .req_opa(req_opa), .req_opb(req_opb),
    .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa),
    .fpu_opb(fpu_opb), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // fpu stand-in: the result appears only in the cycle before the capture edge.
  int          inj_cyc = -1;
  logic [31:0] inj_out;
  logic [7:0]  inj_flags;
  always @(negedge clk) begin
    if (cyc == inj_cyc) begin
      fpu_out   = inj_out;
      fpu_flags = inj_flags;
    end else begin
      fpu_out   = $urandom;
      fpu_flags = 8'($urandom);
    end
  end

  // Reference model state.
  logic [2:0]  m_op;
  logic [1:0]  m_rmode;
  logic [31:0] m_opa, m_opb;
  logic [31:0] exp_data;
  logic [7:0]  exp_flags;
  logic        exp_err;
  int          exp_k;
  int          acc;
  int          retire_cyc;

  function automatic int lat_of(input logic [2:0] op);
    if (op <= 3'd1) return 4;
    if (op == 3'd2) return 5;
    if (op == 3'd3) return 28;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fpu_regs(input string tag);
    check({tag, "_fpu_op"},    32'(fpu_op),    32'(m_op));
    check({tag, "_fpu_rmode"}, 32'(fpu_rmode), 32'(m_rmode));
    check({tag, "_fpu_opa"},   fpu_opa,        m_opa);
    check({tag, "_fpu_opb"},   fpu_opb,        m_opb);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    m_op = '0; m_rmode = '0; m_opa = '0; m_opb = '0;
    check_fpu_regs(tag);
`ifdef FPU_STICKY_FLAGS_EN
    check({tag, "_sticky"}, 32'(sticky_flags), 32'd0);
`endif
  endtask

  // Present a request, wait (bounded) for its accept edge, and arm the model.
  task automatic issue(input logic [2:0] op, input logic [1:0] rm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [7:0] flg);
    bit rdy;
    rdy = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rmode = rm; req_opa = a; req_opb = b;
    for (int i = 0; i < 100; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    #1;
    check("accept", 32'(rdy), 32'd1);
    acc = cyc;
    req_valid = 1'b0;
    if (op <= 3'd3) begin
      m_op = op; m_rmode = rm; m_opa = a; m_opb = b;
      exp_data = res; exp_flags = flg; exp_err = 1'b0;
      inj_out = res; inj_flags = flg; inj_cyc = acc + lat_of(op);
    end else begin
      exp_data = 32'h7FC0_0000; exp_flags = '0; exp_err = 1'b1;
    end
    exp_k = lat_of(op) + 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check_fpu_regs("issue");
  endtask

  // Wait for the response, check it under optional backpressure, then retire it.
  task automatic complete(input int hold);
    int k;
    for (k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) break;
    end
    check("latency",   32'(k),         32'(exp_k));
    check("rsp_data",  rsp_data,       exp_data);
    check("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
    check("rsp_err",   32'(rsp_err),   32'(exp_err));
    check("resp_req_ready", 32'(req_ready), 32'd0);
    check_fpu_regs("resp");
`ifdef FPU_STICKY_FLAGS_EN
    if (!exp_err) sticky_m = sticky_m | exp_flags;
    check("sticky", 32'(sticky_flags), 32'(sticky_m));
`endif
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data",  rsp_data,       exp_data);
      check("bp_flags", 32'(rsp_flags), 32'(exp_flags));
      check("bp_busy",  32'(busy),      32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    retire_cyc = cyc;
    check("retire_valid",     32'(rsp_valid), 32'd0);
    check("retire_req_ready", 32'(req_ready), 32'd1);
    check("retire_busy",      32'(busy),      32'd0);
    check("retire_data_held", rsp_data,       exp_data);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_rmode = '0; req_opa = '0; req_opb = '0;
    rsp_ready = 1'b0;
`ifdef FPU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
    sticky_m   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // 24.0 + 4.0 = 28.0
    issue(3'd0, 2'd0, 32'h41C0_0000, 32'h4080_0000, 32'h41E0_0000, 8'h00);
    complete(0);

    // 24.0 * 4.0 = 96.0, with the next request already waiting on req_valid.
    issue(3'd2, 2'd0, 32'h41C0_0000, 32'h4080_0000, 32'h42C0_0000, 8'h00);
    req_valid = 1'b1; req_op = 3'd0; req_rmode = 2'd1;
    req_opa = 32'h3F80_0000; req_opb = 32'h3F80_0000;
    complete(0);
    issue(3'd0, 2'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    check("b2b_accept_cycle", 32'(acc), 32'(retire_cyc + 1));
    complete(0);

    // 1.0 / 0.0 = +inf with inf and div_by_zero, held under 10 cycles of backpressure.
    issue(3'd3, 2'd0, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 8'h22);
    complete(10);

`ifdef FPU_STICKY_FLAGS_EN
    issue(3'd0, 2'd0, 32'h41C0_0000, 32'h4080_0000, 32'h41E0_0000, 8'h00);
    complete(0);
    check("sticky_accum", 32'(sticky_flags), 32'h22);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    sticky_m   = '0;
    check("sticky_clr", 32'(sticky_flags), 32'h00);
`endif

    // Unsupported op: immediate error response, fpu operands untouched.
    issue(3'd5, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 8'h00);
    complete(0);

    // Reset two cycles into a divide: operation dropped, no response ever appears.
    issue(3'd3, 2'd0, 32'h4000_0000, 32'h4080_0000, 32'h3F00_0000, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    inj_cyc = -1;
    #1;
    check_reset("mid_wait_rst");
    @(negedge clk);
    rst = 1'b0;
`ifdef FPU_STICKY_FLAGS_EN
    sticky_m = '0;
`endif
    repeat (40) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 12; n++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom, 8'($urandom));
      complete(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
